uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 SHALL have port i_Clock, input, 1 bit: the single clock.
REQ-006 SHALL have port i_Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line; idle level is high.
REQ-008 SHALL have port i_Rx_Ready, input, 1 bit: consumer accepts the held word.
REQ-009 SHALL have port o_Rx_DV, output, 1 bit: held word valid.
REQ-010 SHALL have port o_Rx_Byte, output, DATA_BITS wide: received data, LSB first on the line, right-aligned.
REQ-011 SHALL have port o_Parity_Err, output, 1 bit: parity mismatch flag, qualified by o_Rx_DV.
REQ-012 SHALL have port o_Frame_Err, output, 1 bit: stop bit sampled low, qualified by o_Rx_DV.
REQ-013 SHALL have port o_Overrun, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-014 SHALL have port o_Break, output, 1 bit: one-cycle pulse on break detection.

Function
REQ-015 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-017 IDLE: a synchronized low SHALL enter START with the bit counter cleared.
REQ-018 START: sample at count CLKS_PER_BIT/2 (integer divide). Low -> DATA. High -> IDLE (false start, no flags).
REQ-019 DATA: sample every CLKS_PER_BIT cycles after the start midpoint; shift LSB first; exit after DATA_BITS samples to PARITY (if PARITY != 0), otherwise to STOP.
REQ-020 PARITY: one sample, compared with the XOR of the data bits (even) or its inverse (odd); a mismatch sets the pending parity error.
REQ-021 STOP: STOP_BITS samples; any low sample sets the pending framing error.
REQ-022 Frame completion is the midpoint sample of the final stop bit; o_Rx_DV and its data/flags SHALL update on the next clock edge.
REQ-023 o_Rx_DV SHALL stay high with o_Rx_Byte, o_Parity_Err and o_Frame_Err stable until a cycle with i_Rx_Ready=1, then clear on the next edge.
REQ-024 Completion while o_Rx_DV=1 and i_Rx_Ready=0: the new frame SHALL be discarded, held data kept, and o_Overrun pulsed for one cycle.
REQ-025 Completion in the same cycle that i_Rx_Ready=1 clears the held word: the new frame SHALL be accepted with no overrun.
REQ-026 Break (all data bits, parity bit if present, and first stop bit sampled low): no DV update, no framing error; o_Break pulses once; state goes to WAIT_IDLE.
REQ-027 A framing error on a non-break frame SHALL also go to WAIT_IDLE after completion.
REQ-028 WAIT_IDLE SHALL return to IDLE only after the line has been high for CLKS_PER_BIT consecutive cycles.
REQ-029 STOP completion with a high line SHALL return directly to IDLE, ready for back-to-back frames.
REQ-030 The baud counter SHALL be $clog2(CLKS_PER_BIT+1) bits and wrap to 0 at each bit boundary.

Reset
REQ-031 i_Reset low SHALL asynchronously force: state IDLE, counters 0, synchronizer flops 1, o_Rx_DV 0, o_Rx_Byte 0, all flags 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; after release the receiver waits for the next falling edge.

Structure
REQ-033 Parity-mode encodings and the state enumeration SHALL live in the shared package uart_pkg.
REQ-034 The synchronizer SHALL be the sub-module sync_2ff, reset to 1.

Verification (CLKS_PER_BIT=87)
REQ-035 8N1, send 0x3F then 0x3A back-to-back with i_Rx_Ready=1 -> two DV words, 0x3F then 0x3A, no flags.
REQ-036 8E1, send 0x3A with parity bit 1 (wrong) -> DV with 0x3A and o_Parity_Err=1; a correct parity bit 0 -> o_Parity_Err=0.
REQ-037 8N1, stop bit driven low, then line high -> DV with o_Frame_Err=1; next frame 0x55 is received cleanly.
REQ-038 Line low for 30 cycles, then high -> no DV and no flags; a following 0xA5 frame is received.
REQ-039 i_Rx_Ready=0, send 0x11 then 0x22 -> o_Rx_Byte stays 0x11 and o_Overrun pulses once.
REQ-040 Line low for 12 bit-times -> one o_Break pulse, no DV; reset asserted mid-frame -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity-mode encodings, the
// receiver state enumeration and a parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Expected parity bit for right-aligned data (unused upper bits must be 0).
  function automatic logic parity_of(input logic [8:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level, resetting to 1 (line idle).
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with held-word handshake, parity/framing error
// flags, overrun and break pulses.
// Ports:
//   i_Clock, i_Reset (async active-low)
//   i_Rx_Serial  - serial line, idle high
//   i_Rx_Ready   - consumer accepts the held word
//   o_Rx_DV      - held word valid; o_Rx_Byte/o_Parity_Err/o_Frame_Err qualified by it
//   o_Overrun    - one-cycle pulse when a completed frame is dropped
//   o_Break      - one-cycle pulse on break detection
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Break
);

  localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  logic rx_s;

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        cnt_q,       cnt_d;
  logic [BIT_W-1:0]     bit_idx_q,   bit_idx_d;
  logic                 stop_idx_q,  stop_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 par_bit_q,   par_bit_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 dv_q,        dv_d;
  logic [DATA_BITS-1:0] byte_q,      byte_d;
  logic                 perr_q,      perr_d;
  logic                 ferr_q,      ferr_d;
  logic                 ovr_q,       ovr_d;
  logic                 brk_q,       brk_d;

  logic bit_tick_c;
  logic break_cand_c;
  logic stop_err_c;
  logic par_exp_c;

  sync_2ff u_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

  // Bit-centre sample point once aligned to the start-bit midpoint.
  assign bit_tick_c   = (cnt_q == CW'(CLKS_PER_BIT - 1));
  // Break needs all data bits and the parity bit (if any) low.
  assign break_cand_c = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_bit_q);
  assign stop_err_c   = ferr_pend_q | ~rx_s;
  assign par_exp_c    = parity_of(9'(shift_q), PARITY);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    dv_d        = dv_q;
    byte_d      = byte_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = 1'b0;
    brk_d       = 1'b0;

    // Handshake clears the held word; a completion below may reload it.
    if (dv_q && i_Rx_Ready) begin
      dv_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CW'(HALF)) begin
          cnt_d       = '0;
          bit_idx_d   = '0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
          par_bit_d   = 1'b0;
          state_d     = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (bit_tick_c) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PARITY: begin
        if (bit_tick_c) begin
          cnt_d       = '0;
          par_bit_d   = rx_s;
          perr_pend_d = (rx_s != par_exp_c);
          stop_idx_d  = 1'b0;
          state_d     = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (bit_tick_c) begin
          cnt_d = '0;
          if (!stop_idx_q && !rx_s && break_cand_c) begin
            brk_d   = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (dv_q && !i_Rx_Ready) begin
              ovr_d = 1'b1;
            end else begin
              dv_d   = 1'b1;
              byte_d = shift_q;
              perr_d = perr_pend_q;
              ferr_d = stop_err_c;
            end
            state_d = stop_err_c ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            ferr_pend_d = stop_err_c;
            stop_idx_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        // Count consecutive high cycles; any low restarts the count.
        if (rx_s) begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      dv_q        <= 1'b0;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      dv_q        <= dv_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      brk_q       <= brk_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Overrun    = ovr_q;
  assign o_Break      = brk_q;

endmodule
